// File: rtl/pcm_to_i2s.sv
// pcm_to_i2s: I2S master transmitter.
// Accepts left/right PCM pairs over a valid/ready handshake into a one-deep
// holding register and serialises them MSB-first on sd. It also generates the
// bit clock (sck) and word select (ws) from clk.
//
// Ports:
//   clk       system clock
//   reset     synchronous, active-high
//   enable    run request (level)
//   in_valid  sample pair valid
//   in_ready  holding register empty (registered)
//   in_left   left sample, sent in the ws=0 slot
//   in_right  right sample, sent in the ws=1 slot
//   sck       I2S bit clock
//   ws        I2S word select
//   sd        I2S serial data
//   busy      high while RUN or DRAIN
//   underrun  one-clk pulse when a frame starts with no pair held
module pcm_to_i2s #(
  parameter int SAMPLE_BITS = 8,
  parameter int SLOT_BITS   = 8,
  parameter int CLK_DIV     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SAMPLE_BITS-1:0] in_left,
  input  logic [SAMPLE_BITS-1:0] in_right,
  output logic                   sck,
  output logic                   ws,
  output logic                   sd,
  output logic                   busy,
  output logic                   underrun
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int PW = $clog2(FRAME_BITS);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST    = DW'(CLK_DIV - 1);
  localparam logic [PW-1:0] POS_LAST    = PW'(FRAME_BITS - 1);
  localparam logic [PW-1:0] WS_FIRST    = PW'(SLOT_BITS - 1);
  localparam logic [PW-1:0] WS_LAST     = PW'(2 * SLOT_BITS - 2);
  localparam logic [PW-1:0] LEFT_LAST   = PW'(SAMPLE_BITS - 1);
  localparam logic [PW-1:0] RIGHT_FIRST = PW'(SLOT_BITS);
  localparam logic [PW-1:0] RIGHT_LAST  = PW'(SLOT_BITS + SAMPLE_BITS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                 state;
  logic [DW-1:0]          div_cnt;
  logic [PW-1:0]          pos;
  logic [PW-1:0]          pos_next;
  logic [SAMPLE_BITS-1:0] hold_l;
  logic [SAMPLE_BITS-1:0] hold_r;
  logic [SAMPLE_BITS-1:0] shift_l;
  logic [SAMPLE_BITS-1:0] shift_r;
  logic [SAMPLE_BITS-1:0] shift_l_next;
  logic [SAMPLE_BITS-1:0] shift_r_next;
  logic                   hold_full;
  logic                   hold_full_next;
  logic                   accept;
  logic                   tick;
  logic                   wrap;
  logic                   start_idle;
  logic                   go_idle;
  logic                   frame_load;

  always_comb begin
    accept       = in_valid && in_ready;
    // A bit tick is the registered 1->0 transition of sck.
    tick         = (state != IDLE) && sck && (div_cnt == DIV_LAST);
    wrap         = tick && (pos == POS_LAST);
    pos_next     = wrap ? '0 : pos + PW'(1);
    start_idle   = (state == IDLE) && enable && hold_full;
    go_idle      = wrap && (state == DRAIN) && !enable;
    frame_load   = start_idle || (wrap && !go_idle);
    shift_l_next = shift_l << 1;
    shift_r_next = shift_r << 1;
    hold_full_next = hold_full;
    if (accept) begin
      hold_full_next = 1'b1;
    end else if (frame_load) begin
      hold_full_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      div_cnt   <= '0;
      pos       <= '0;
      sck       <= 1'b0;
      ws        <= 1'b0;
      sd        <= 1'b0;
      busy      <= 1'b0;
      underrun  <= 1'b0;
      hold_full <= 1'b0;
      in_ready  <= 1'b1;
      hold_l    <= '0;
      hold_r    <= '0;
      shift_l   <= '0;
      shift_r   <= '0;
    end else begin
      underrun  <= 1'b0;
      hold_full <= hold_full_next;
      in_ready  <= !hold_full_next;
      if (accept) begin
        hold_l <= in_left;
        hold_r <= in_right;
      end

      case (state)
        IDLE: begin
          sck     <= 1'b0;
          ws      <= 1'b0;
          sd      <= 1'b0;
          div_cnt <= '0;
          pos     <= '0;
          if (start_idle) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN, DRAIN: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            sck     <= !sck;
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end

          if (tick && !wrap) begin
            pos <= pos_next;
            // ws leads the slot boundary by one bit.
            ws  <= (pos_next >= WS_FIRST) && (pos_next <= WS_LAST);
            if (pos_next <= LEFT_LAST) begin
              shift_l <= shift_l_next;
              sd      <= shift_l_next[SAMPLE_BITS-1];
            end else if (pos_next == RIGHT_FIRST) begin
              sd <= shift_r[SAMPLE_BITS-1];
            end else if ((pos_next > RIGHT_FIRST) && (pos_next <= RIGHT_LAST)) begin
              shift_r <= shift_r_next;
              sd      <= shift_r_next[SAMPLE_BITS-1];
            end else begin
              sd <= 1'b0;
            end
          end

          if (go_idle) begin
            state   <= IDLE;
            busy    <= 1'b0;
            sck     <= 1'b0;
            ws      <= 1'b0;
            sd      <= 1'b0;
            pos     <= '0;
            div_cnt <= '0;
          end else if ((state == RUN) && !enable) begin
            state <= DRAIN;
          end else if (wrap) begin
            state <= RUN;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      // Frame start: take the held pair, or send a zero frame and flag it.
      if (frame_load) begin
        pos     <= '0;
        div_cnt <= '0;
        sck     <= 1'b0;
        ws      <= 1'b0;
        if (hold_full) begin
          shift_l <= hold_l;
          shift_r <= hold_r;
          sd      <= hold_l[SAMPLE_BITS-1];
        end else begin
          shift_l  <= '0;
          shift_r  <= '0;
          sd       <= 1'b0;
          underrun <= 1'b1;
        end
      end
    end
  end

endmodule
